digit_serial_subtractor: RTL and testbench

- Multi-cycle subtractor computing diff = a - b - bin over WIDTH bits.
- Processes DIGIT bits per clock and ripples the borrow between digits through a register.
- Serves as the area-lean subtract path that pairs with the combinational ripple-carry adder in the arithmetic library.
- Sits between a valid/ready producer and a valid/ready consumer; one operation is in flight at a time.

---
 rtl/digit_serial_subtractor.sv | 125 ++++++++++++
 tb/tb_digit_serial_subtractor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per
// clock, borrow carried between digits in a register. One operation in flight.
module digit_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
      $error("digit_serial_subtractor: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. in_ready is high only in IDLE, out_valid only in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [SW-1:0]    sel;
  logic [DIGIT:0]   step;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    sel      = SW'(int'(cnt_q) * DIGIT);
    // One digit of the subtraction; the extra top bit is the outgoing borrow.
    step     = {1'b0, a_q[sel +: DIGIT]} - {1'b0, b_q[sel +: DIGIT]}
             - (DIGIT + 1)'(borrow_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          diff_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[sel +: DIGIT] = step[DIGIT-1:0];
        borrow_d             = step[DIGIT];
        if (cnt_q == LAST) begin
          bout_d  = step[DIGIT];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (step[DIGIT-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Bench for digit_serial_subtractor: four instances (DIGIT = 1, 2, 4, 8) at
// WIDTH = 8, directed cases plus random operands with random output stalls.
module tb_digit_serial_subtractor;

  logic            clk;
  logic            rst_n;
  logic [3:0]      in_valid_v;
  logic [3:0]      in_ready_v;
  logic [3:0][7:0] a_v;
  logic [3:0][7:0] b_v;
  logic [3:0]      bin_v;
  logic [3:0]      out_valid_v;
  logic [3:0]      out_ready_v;
  logic [3:0][7:0] diff_v;
  logic [3:0]      bout_v;
  logic [3:0]      ovf_v;
  logic [3:0][1:0] state_dbg_v;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    digit_serial_subtractor #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .bin       (bin_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .diff      (diff_v[g]),
      .bout      (bout_v[g]),
      .ovf       (ovf_v[g]),
      .state_dbg (state_dbg_v[g])
    );
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the whole word.
  task automatic model(input logic [7:0] av, input logic [7:0] bv, input logic biv,
                       output logic [7:0] d, output logic bo, output logic ov);
    int full;
    full = int'(av) - int'(bv) - int'(biv);
    d    = full[7:0];
    bo   = (full < 0);
    ov   = (av[7] != bv[7]) && (d[7] != av[7]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle_reset(input int k);
    check($sformatf("rst_diff[%0d]", k), diff_v[k], 0);
    check($sformatf("rst_bout[%0d]", k), bout_v[k], 0);
    check($sformatf("rst_ovf[%0d]", k), ovf_v[k], 0);
    check($sformatf("rst_out_valid[%0d]", k), out_valid_v[k], 0);
    check($sformatf("rst_in_ready[%0d]", k), in_ready_v[k], 1);
  endtask

  // One full transaction on instance k. stall = cycles out_ready is held low
  // after out_valid; spam drives a rejected in_valid (a=0xFF) during the stall.
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic biv, input logic [7:0] ed, input logic eb,
                        input logic eo, input int stall, input bit spam);
    int waitc;
    waitc = 0;
    while (!in_ready_v[k] && waitc < 50) begin
      tick();
      waitc++;
    end
    check($sformatf("in_ready_before[%0d]", k), in_ready_v[k], 1);
    in_valid_v[k]  = 1'b1;
    a_v[k]         = av;
    b_v[k]         = bv;
    bin_v[k]       = biv;
    out_ready_v[k] = (stall == 0);
    tick();
    in_valid_v[k] = 1'b0;
    a_v[k]        = 8'($urandom);
    b_v[k]        = 8'($urandom);
    bin_v[k]      = 1'($urandom);
    check($sformatf("in_ready_busy[%0d]", k), in_ready_v[k], 0);
    waitc = 0;
    while (!out_valid_v[k] && waitc < 100) begin
      tick();
      waitc++;
    end
    check($sformatf("latency[%0d]", k), waitc, 8 >> k);
    check($sformatf("diff[%0d] %02h-%02h-%0d", k, av, bv, biv), diff_v[k], ed);
    check($sformatf("bout[%0d] %02h-%02h-%0d", k, av, bv, biv), bout_v[k], eb);
    check($sformatf("ovf[%0d] %02h-%02h-%0d", k, av, bv, biv), ovf_v[k], eo);
    for (int s = 0; s < stall; s++) begin
      if (spam) begin
        in_valid_v[k] = 1'b1;
        a_v[k]        = 8'hFF;
        b_v[k]        = 8'h00;
      end
      tick();
      check($sformatf("hold_valid[%0d]", k), out_valid_v[k], 1);
      check($sformatf("hold_in_ready[%0d]", k), in_ready_v[k], 0);
      check($sformatf("hold_diff[%0d]", k), diff_v[k], ed);
      check($sformatf("hold_bout[%0d]", k), bout_v[k], eb);
      check($sformatf("hold_ovf[%0d]", k), ovf_v[k], eo);
    end
    in_valid_v[k]  = 1'b0;
    out_ready_v[k] = 1'b1;
    tick();
    check($sformatf("post_out_valid[%0d]", k), out_valid_v[k], 0);
    check($sformatf("post_in_ready[%0d]", k), in_ready_v[k], 1);
    check($sformatf("post_diff_kept[%0d]", k), diff_v[k], ed);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t dir_tab[6];

  initial begin
    logic [7:0] ra, rb, ed;
    logic       rbin, eb, eo;

    dir_tab[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    dir_tab[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    dir_tab[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    dir_tab[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    dir_tab[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    dir_tab[5] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

    rst_n       = 1'b0;
    in_valid_v  = '0;
    a_v         = '0;
    b_v         = '0;
    bin_v       = '0;
    out_ready_v = '0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) check_idle_reset(k);
    rst_n = 1'b1;
    tick();

    // Directed table on every digit size
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 6; i++)
        run_op(k, dir_tab[i].a, dir_tab[i].b, dir_tab[i].bin,
               dir_tab[i].d, dir_tab[i].bo, dir_tab[i].ov, 0, 1'b0);

    // Backpressure with a rejected offer, then a normal op
    run_op(1, 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 5, 1'b1);
    run_op(1, 8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);

    // Reset mid-RUN, after a result with bout=1 so the clear is visible
    run_op(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    in_valid_v[1] = 1'b1;
    a_v[1]        = 8'h12;
    b_v[1]        = 8'h34;
    bin_v[1]      = 1'b0;
    tick();
    in_valid_v[1] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_reset(1);
    tick();
    rst_n = 1'b1;
    tick();
    check("no_partial_after_reset", out_valid_v[1], 0);
    run_op(1, 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 0, 1'b0);

    // Random sweep against the reference model
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 25; i++) begin
        ra   = 8'($urandom);
        rb   = 8'($urandom);
        rbin = 1'($urandom);
        if (i % 8 == 0) ra = 8'h80;
        if (i % 8 == 1) rb = 8'h00;
        model(ra, rb, rbin, ed, eb, eo);
        run_op(k, ra, rb, rbin, ed, eb, eo, $urandom_range(0, 3), 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
